// File: rtl/wb_stage_if.sv
// Writeback request bus: handshake, destination/load-shape fields and the
// non-memory operand sources.
interface wb_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned LANE_W = $clog2(XLEN / 8);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_sel_i;
  logic [REG_AW-1:0] req_rd_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [LANE_W-1:0] req_addr_lo_i;
  logic [XLEN-1:0]   alu_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   csr_i;

  modport master (
    output req_valid_i, req_sel_i, req_rd_i, req_size_i, req_unsigned_i,
           req_addr_lo_i, alu_i, pc_plus4_i, csr_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_sel_i, req_rd_i, req_size_i, req_unsigned_i,
           req_addr_lo_i, alu_i, pc_plus4_i, csr_i,
    output req_ready_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/PC+4/CSR/load data and issues one register-file write.
// Optional macro WB_CSR_EN: when defined, sel 3 writes csr_i; otherwise it writes zero.
module wb_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  wb_stage_if.slave         req,
  input  logic              dmem_valid_i,
  input  logic [XLEN-1:0]   dmem_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              busy_o
);
  localparam int unsigned LANE_W = $clog2(XLEN / 8);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  localparam logic [1:0] SEL_MEM = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;
  localparam logic [1:0] SEL_CSR = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [LANE_W-1:0] lo_q;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [XLEN-1:0]   rf_wdata_q;

  logic              accept;
  logic              mem_done;
  logic [XLEN-1:0]   csr_val;
  logic [XLEN-1:0]   src_val;
  logic [LANE_W-1:0] lane_off;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_val;

  assign req.req_ready_o = rst_ni && (state_q == IDLE);
  assign busy_o          = rst_ni && (state_q != IDLE);
  assign accept          = req.req_valid_i && (state_q == IDLE);
  assign mem_done        = dmem_valid_i && (state_q == WAIT_MEM);

`ifdef WB_CSR_EN
  assign csr_val = req.csr_i;
`else
  logic unused_csr;
  assign unused_csr = ^req.csr_i;
  assign csr_val    = '0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (req.req_sel_i == SEL_MEM) ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        if (dmem_valid_i) state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Non-memory source mux
  always_comb begin
    src_val = '0;
    case (req.req_sel_i)
      SEL_ALU: src_val = req.alu_i;
      SEL_PC4: src_val = req.pc_plus4_i;
      SEL_CSR: src_val = csr_val;
      default: src_val = '0;
    endcase
  end

  // Load extraction: align the lane down to the access size, then extend
  always_comb begin
    lane_off = lo_q;
    case (size_q)
      2'd1:    lane_off = lo_q & ~LANE_W'(1);
      2'd2:    lane_off = lo_q & ~LANE_W'(3);
      default: lane_off = lo_q;
    endcase
    shifted  = dmem_i >> {lane_off, 3'b000};
    load_val = dmem_i;
    case (size_q)
      2'd0: load_val = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1: load_val = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2: load_val = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_val = dmem_i;
    endcase
  end

  // Capture registers and write port; rd = 0 suppresses the write entirely
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q       <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      lo_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (accept) begin
        rd_q <= req.req_rd_i;
        if (req.req_sel_i == SEL_MEM) begin
          size_q <= req.req_size_i;
          uns_q  <= req.req_unsigned_i;
          lo_q   <= req.req_addr_lo_i;
        end else begin
          rf_we_q <= |req.req_rd_i;
          if (|req.req_rd_i) begin
            rf_waddr_q <= req.req_rd_i;
            rf_wdata_q <= src_val;
          end
        end
      end else if (mem_done) begin
        rf_we_q <= |rd_q;
        if (|rd_q) begin
          rf_waddr_q <= rd_q;
          rf_wdata_q <= load_val;
        end
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table of single writebacks plus
// back-to-back and reset-abort sequences.
module tb_wb_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dmem_valid;
  logic [XLEN-1:0]   dmem;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  wb_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req          (bus),
    .dmem_valid_i (dmem_valid),
    .dmem_i       (dmem),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] src;
    logic [31:0] dmem;
    int          waits;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

`ifdef WB_CSR_EN
  localparam logic [31:0] CSR_EXP = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] CSR_EXP = 32'h0000_0000;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_valid_i    = 1'b0;
    bus.req_sel_i      = 2'd0;
    bus.req_rd_i       = '0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_lo_i  = '0;
    bus.alu_i          = '0;
    bus.pc_plus4_i     = '0;
    bus.csr_i          = '0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    check($sformatf("v%0d ready_idle", i), 64'(bus.req_ready_o), 64'(1));
    bus.req_valid_i    = 1'b1;
    bus.req_sel_i      = v.sel;
    bus.req_rd_i       = v.rd;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_addr_lo_i  = v.lo;
    bus.alu_i          = (v.sel == 2'd1) ? v.src : ~v.src;
    bus.pc_plus4_i     = (v.sel == 2'd2) ? v.src : ~v.src;
    bus.csr_i          = (v.sel == 2'd3) ? v.src : ~v.src;
    // a memory response in the accept cycle must be ignored
    dmem_valid = 1'b1;
    dmem       = 32'hFFFF_FFFF;
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_rd_i    = 5'h1F;
    bus.alu_i       = 32'hA5A5_A5A5;
    bus.pc_plus4_i  = 32'hA5A5_A5A5;
    bus.csr_i       = 32'hA5A5_A5A5;
    dmem_valid      = 1'b0;
    if (v.sel == 2'd0) begin
      check($sformatf("v%0d we_wait", i), 64'(rf_we), 64'(0));
      check($sformatf("v%0d busy_wait", i), 64'(busy), 64'(1));
      for (int w = 0; w < v.waits; w++) begin
        tick();
        check($sformatf("v%0d we_wait%0d", i, w), 64'(rf_we), 64'(0));
      end
      dmem_valid = 1'b1;
      dmem       = v.dmem;
      tick();
      dmem_valid = 1'b1;
      dmem       = 32'h0F0F_0F0F;
    end else begin
      dmem_valid = 1'b1;
    end
    check($sformatf("v%0d we", i), 64'(rf_we), 64'(v.exp_we));
    check($sformatf("v%0d waddr", i), 64'(rf_waddr), 64'(v.exp_waddr));
    check($sformatf("v%0d wdata", i), 64'(rf_wdata), 64'(v.exp_wdata));
    check($sformatf("v%0d ready_write", i), 64'(bus.req_ready_o), 64'(0));
    tick();
    dmem_valid = 1'b0;
    check($sformatf("v%0d we_after", i), 64'(rf_we), 64'(0));
    check($sformatf("v%0d busy_after", i), 64'(busy), 64'(0));
    check($sformatf("v%0d waddr_hold", i), 64'(rf_waddr), 64'(v.exp_waddr));
    check($sformatf("v%0d wdata_hold", i), 64'(rf_wdata), 64'(v.exp_wdata));
  endtask

  initial begin
    //            sel   rd     size  uns   lo    src           dmem          w  we    waddr  wdata
    vecs[0]  = '{2'd1, 5'd5,  2'd0, 1'b0, 2'd0, 32'h1234_5678, 32'h0,        0, 1'b1, 5'd5,  32'h1234_5678};
    vecs[1]  = '{2'd2, 5'd7,  2'd0, 1'b0, 2'd0, 32'h0000_1004, 32'h0,        0, 1'b1, 5'd7,  32'h0000_1004};
    vecs[2]  = '{2'd3, 5'd9,  2'd0, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0,        0, 1'b1, 5'd9,  CSR_EXP};
    vecs[3]  = '{2'd0, 5'd10, 2'd0, 1'b0, 2'd2, 32'h0,         32'h0080_0000, 3, 1'b1, 5'd10, 32'hFFFF_FF80};
    vecs[4]  = '{2'd0, 5'd11, 2'd1, 1'b1, 2'd2, 32'h0,         32'h8001_0000, 1, 1'b1, 5'd11, 32'h0000_8001};
    vecs[5]  = '{2'd0, 5'd12, 2'd0, 1'b1, 2'd3, 32'h0,         32'hAB00_0000, 0, 1'b1, 5'd12, 32'h0000_00AB};
    vecs[6]  = '{2'd0, 5'd13, 2'd1, 1'b0, 2'd3, 32'h0,         32'h8001_0000, 2, 1'b1, 5'd13, 32'hFFFF_8001};
    vecs[7]  = '{2'd0, 5'd14, 2'd2, 1'b0, 2'd3, 32'h0,         32'h8765_4321, 0, 1'b1, 5'd14, 32'h8765_4321};
    vecs[8]  = '{2'd0, 5'd31, 2'd3, 1'b0, 2'd1, 32'h0,         32'hCAFE_F00D, 1, 1'b1, 5'd31, 32'hCAFE_F00D};
    vecs[9]  = '{2'd0, 5'd1,  2'd0, 1'b0, 2'd0, 32'h0,         32'h1234_567F, 0, 1'b1, 5'd1,  32'h0000_007F};
    vecs[10] = '{2'd1, 5'd0,  2'd0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,        0, 1'b0, 5'd1,  32'h0000_007F};
    vecs[11] = '{2'd2, 5'd0,  2'd0, 1'b0, 2'd0, 32'h0000_2004, 32'h0,        0, 1'b0, 5'd1,  32'h0000_007F};

    rst_n      = 1'b0;
    dmem_valid = 1'b0;
    dmem       = '0;
    idle_bus();

    // reset values
    #1;
    check("rst ready", 64'(bus.req_ready_o), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    tick();
    check("rst we", 64'(rf_we), 64'(0));
    check("rst waddr", 64'(rf_waddr), 64'(0));
    check("rst wdata", 64'(rf_wdata), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("rst release ready", 64'(bus.req_ready_o), 64'(1));

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // back-to-back ALU writes with valid held high: one write every two cycles
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = 2'd1;
    bus.req_rd_i    = 5'd4;
    bus.alu_i       = 32'h1111_1111;
    tick();
    check("b2b we1", 64'(rf_we), 64'(1));
    check("b2b wdata1", 64'(rf_wdata), 64'(32'h1111_1111));
    bus.alu_i = 32'h2222_2222;
    tick();
    check("b2b gap we", 64'(rf_we), 64'(0));
    check("b2b gap ready", 64'(bus.req_ready_o), 64'(1));
    check("b2b gap wdata", 64'(rf_wdata), 64'(32'h1111_1111));
    tick();
    check("b2b we2", 64'(rf_we), 64'(1));
    check("b2b wdata2", 64'(rf_wdata), 64'(32'h2222_2222));
    idle_bus();
    tick();
    check("b2b end we", 64'(rf_we), 64'(0));

    // reset while waiting for memory aborts the write
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = 2'd0;
    bus.req_rd_i    = 5'd3;
    bus.req_size_i  = 2'd2;
    tick();
    idle_bus();
    check("abort busy_wait", 64'(busy), 64'(1));
    rst_n      = 1'b0;
    dmem_valid = 1'b1;
    dmem       = 32'h5555_5555;
    #1;
    check("abort rst ready", 64'(bus.req_ready_o), 64'(0));
    check("abort rst busy", 64'(busy), 64'(0));
    tick();
    check("abort we0", 64'(rf_we), 64'(0));
    check("abort waddr", 64'(rf_waddr), 64'(0));
    check("abort wdata", 64'(rf_wdata), 64'(0));
    rst_n = 1'b1;
    #1;
    check("abort release ready", 64'(bus.req_ready_o), 64'(1));
    tick();
    check("abort we1", 64'(rf_we), 64'(0));
    check("abort busy1", 64'(busy), 64'(0));
    dmem_valid = 1'b0;
    tick();
    check("abort we2", 64'(rf_we), 64'(0));
    check("abort ready2", 64'(bus.req_ready_o), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL: parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL: parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL: localparam LANE_W = $clog2(XLEN/8), width of the byte-offset field.
REQ-004 SHALL: clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL: rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL: req_valid_i  input  1  writeback request present.
REQ-007 SHALL: req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-008 SHALL: req_sel_i  input  2  source select: 0 MEM, 1 ALU, 2 PC4, 3 CSR.
REQ-009 SHALL: req_rd_i  input  REG_AW  destination register.
REQ-010 SHALL: req_size_i  input  2  load size: 0 byte, 1 half, 2 word (32b), 3 full XLEN.
REQ-011 SHALL: req_unsigned_i  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL: req_addr_lo_i  input  LANE_W  load address byte offset.
REQ-013 SHALL: alu_i, pc_plus4_i, csr_i  input  XLEN each  non-memory sources, sampled at accept.
REQ-014 SHALL: dmem_valid_i  input  1 and dmem_i  input  XLEN  memory response.
REQ-015 SHALL: rf_we_o  output  1, rf_waddr_o  output  REG_AW, rf_wdata_o  output  XLEN  register-file write port.
REQ-016 SHALL: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL: FSM states IDLE, WAIT_MEM, WRITE; req_ready_o = 1 only in IDLE.
REQ-018 SHALL: accept in IDLE with sel != MEM -> capture selected source and rd, go to WRITE.
REQ-019 SHALL: accept in IDLE with sel = MEM -> capture rd, size, unsigned, addr_lo, go to WAIT_MEM.
REQ-020 SHALL: in WAIT_MEM, dmem_valid_i = 1 -> capture extracted load data, go to WRITE; otherwise hold indefinitely.
REQ-021 SHALL: dmem_valid_i ignored in IDLE and WRITE, including in the accept cycle.
REQ-022 SHALL: in WRITE, rf_we_o = 1 for exactly one cycle with registered rf_waddr_o/rf_wdata_o, then IDLE.
REQ-023 SHALL: latency, accept to rf_we_o: 1 cycle for non-MEM; 1 cycle after the dmem_valid_i cycle for MEM.
REQ-024 SHALL: rd = 0 -> FSM sequence unchanged, rf_we_o held 0 in WRITE.
REQ-025 SHALL: byte extract dmem_i[8*addr_lo +: 8]; half uses addr_lo with bit 0 ignored; word uses addr_lo with bits [1:0] ignored; full ignores addr_lo.
REQ-026 SHALL: extracted field extended to XLEN per req_unsigned_i; size 3 passes dmem_i unchanged; size 2 with XLEN = 32 passes unchanged.
REQ-027 SHALL: rf_waddr_o/rf_wdata_o hold last written value outside WRITE; rf_we_o = 0 outside WRITE.
REQ-028 SHALL: back-to-back throughput, non-MEM: one write per 2 cycles (IDLE, WRITE).

Reset
REQ-029 SHALL: rst_ni = 0 at a rising edge -> state IDLE, rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0, captured fields 0.
REQ-030 SHALL: reset in WAIT_MEM or WRITE aborts the pending write; no rf_we_o pulse follows.
REQ-031 SHALL: req_ready_o = 0 and busy_o = 0 while rst_ni = 0.

Configuration
REQ-032 SHALL: macro WB_CSR_EN defined -> sel 3 writes csr_i.
REQ-033 SHALL: WB_CSR_EN undefined -> sel 3 writes zero; csr_i port present but unused.

Verification
REQ-034 SHALL: ALU accept, alu_i=0x1234_5678, rd=5 -> next cycle rf_we_o=1, waddr=5, wdata=0x1234_5678.
REQ-035 SHALL: MEM byte signed, addr_lo=2, dmem_i=0x0080_0000 after 3 wait cycles -> wdata=0xFFFF_FF80 one cycle after dmem_valid_i.
REQ-036 SHALL: MEM half unsigned, addr_lo=2, dmem_i=0x8001_0000 -> wdata=0x0000_8001.
REQ-037 SHALL: PC4 accept with rd=0 -> rf_we_o never asserted, FSM returns to IDLE after 2 cycles.
REQ-038 SHALL: rst_ni low in WAIT_MEM, then dmem_valid_i=1 -> no write, req_ready_o=1 after reset release.
REQ-039 SHALL: sel 3, csr_i=0xDEAD_BEEF -> wdata=0xDEAD_BEEF with WB_CSR_EN, 0x0 without.
